countdown_sec_ctrl: RTL and testbench
=====================================

# countdown_sec_ctrl

Seconds countdown controller sitting directly downstream of the 1 ms timer. It gates that timer through `timer_en` and consumes its `TimeOut` pulse as `ms_tick`. It accumulates ticks into whole seconds and decrements a 2-digit BCD remaining-time value, and reports expiry. Its outputs feed the seven-segment display and the top-level access/game FSM.

## Interface
- `MS_PER_SEC`, 1000, number of ms ticks per second decrement. Legal range 2..1023.
- `INIT_TENS`, 4'd6, tens digit loaded at reset.
- `INIT_ONES`, 4'd0, ones digit loaded at reset.
- `WARN_SEC`, 7'd10, warning threshold in seconds. Used only under the configuration macro.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `ms_tick` in 1: `TimeOut` from the 1 ms timer.
- `load` in 1: load `load_tens`/`load_ones`.
- `load_tens` in 4: BCD tens digit to load.
- `load_ones` in 4: BCD ones digit to load.
- `start` in 1: start or resume the countdown.
- `pause` in 1: pause the countdown.
- `timer_en` out 1: enable to the 1 ms timer.
- `sec_tens` out 4: remaining seconds, tens digit (BCD).
- `sec_ones` out 4: remaining seconds, ones digit (BCD).
- `running` out 1: high in RUN.
- `expired` out 1: level, high in EXPIRED.
- `expire_pulse` out 1: one-cycle pulse on entry to EXPIRED.
- `warn` out 1: low-time warning.

## Operation
- **States:** IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- **Tick event:** `ms_tick`=1 AND `ms_tick_d`=0, where `ms_tick_d` is `ms_tick` registered one cycle.
  - This is mandatory: the upstream `TimeOut` can stay stuck high while its enable is low.
- **Internal counter:** `ms_cnt` is 10 bits and runs 0..`MS_PER_SEC`-1.
- **Priority, every cycle:** `load` > `start` > `pause` > tick event.
- **load (any state):**
  - Digits take `load_*`; any digit >9 is clamped to 9.
  - `ms_cnt` is set to 0 and the next state is IDLE.
- **start:**
  - In IDLE or PAUSE with value ≠ 00: go to RUN.
  - In IDLE with value 00: go to EXPIRED.
  - Ignored in RUN and EXPIRED.
- **pause:**
  - In RUN: go to PAUSE, with `ms_cnt` and digits held.
  - Ignored elsewhere.
  - `pause` is level-sampled and has no effect while `start` is also high.
- **Tick event in RUN:**
  - If `ms_cnt`==`MS_PER_SEC`-1: set `ms_cnt` to 0 and decrement the value.
  - Otherwise: `ms_cnt` +1.
  - Tick events outside RUN are ignored.
- **BCD decrement:**
  - If ones>0: ones-1.
  - Otherwise: ones=9 and tens-1.
  - No wrap past 00 is possible. If the result is 00, the state goes to EXPIRED in the same update.
- **EXPIRED:** digits stay 00 and the state is exited only by `load` or reset.
- **`timer_en`:** equals (next state == RUN), registered, so it is high in exactly the cycles the state is RUN.

## Timing
- **Reset values (`rst`=0 at a clk edge):**
  - State IDLE, `ms_cnt`=0, `ms_tick_d`=0.
  - `sec_tens`=`INIT_TENS`, `sec_ones`=`INIT_ONES`.
  - `timer_en`=0, `running`=0, `expired`=0, `expire_pulse`=0, `warn`=0.
- **Reset mid-RUN:** same reset values on the next edge; no `expire_pulse` is generated.
- **`start` latency:** `start` sampled at edge N gives `running`=1 and `timer_en`=1 after edge N.
- **Digit update latency:** digits update on the edge after the edge where the tick event is detected, i.e. 2 edges after `ms_tick` rises.
- **Expiry timing:** `expired`, `expire_pulse` and digits=00 all become visible together after the same edge.
  - `expire_pulse` is high for exactly one cycle.
  - `timer_en` falls on that same edge.
- **PAUSE/resume:** the sub-second `ms_cnt` is preserved. The upstream timer discards its partial ms when `en` drops; that loss (<1 ms per pause) is accepted.
- **`load` and a tick event in the same cycle:** `load` wins and the tick is dropped.

## Configuration
- Macro `COUNTDOWN_WARN_EN`.
- **Defined:**
  - `warn` is registered high when state ∈ {RUN, PAUSE} and remaining seconds (tens×10+ones, 7-bit) ≤ `WARN_SEC` and ≠ 0.
  - `warn` is low otherwise, including in EXPIRED.
- **Undefined:** the `warn` port still exists, tied to 0, and the comparator logic is not built.

## Test plan
Run with `MS_PER_SEC`=4.
- **Reset then start:** reset, then `start` pulse → `running`=1 and `timer_en`=1 next cycle; digits 6,0.
- **Decrement across a tens boundary:**
  - Stimulus: `load` 1,0, `start`, then 4 isolated `ms_tick` pulses.
  - Response: digits 0,9 two edges after the 4th rise.
  - Then 36 more pulses → digits 0,0, `expired`=1, single-cycle `expire_pulse`, `timer_en`=0.
- **Stuck-high tick:**
  - Stimulus: hold `ms_tick`=1 for 20 cycles in RUN.
  - Response: exactly one tick is counted; `ms_cnt`=1 and digits are unchanged.
- **Pause/resume:**
  - Stimulus: 2 ticks, `pause`, 3 ticks, `start`, 2 ticks.
  - Response: exactly one decrement; the ticks during PAUSE are ignored and `timer_en`=0 in PAUSE.
- **Load edge cases:**
  - `load` with tens=12, ones=15 → digits 9,9.
  - `load` 0,0 then `start` → EXPIRED next cycle with `expire_pulse`.
  - `load` asserted together with `start` and a tick in RUN → IDLE with the loaded value.
- **Warn (`COUNTDOWN_WARN_EN` defined, `WARN_SEC`=10):**
  - Load 1,1 and run: `warn`=0 at 11 and `warn`=1 at 10.
  - `warn` stays 1 through 01 and drops to 0 at expiry.
  - With the macro undefined, `warn` stays 0 throughout.

Source files
------------

// File: rtl/countdown_sec_ctrl.sv
// Seconds countdown controller: gates the 1 ms timer, counts its ticks into seconds, and
// decrements a 2-digit BCD value down to expiry. Optional low-time warn under `COUNTDOWN_WARN_EN.
module countdown_sec_ctrl #(
  parameter int         MS_PER_SEC = 1000,
  parameter logic [3:0] INIT_TENS  = 4'd6,
  parameter logic [3:0] INIT_ONES  = 4'd0,
  parameter logic [6:0] WARN_SEC   = 7'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ms_tick,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  output logic       timer_en,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       expire_pulse,
  output logic       warn
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [9:0] CNT_LAST = 10'(MS_PER_SEC - 1);

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  state_t     state_r, state_n;
  logic [3:0] tens_r, tens_n;
  logic [3:0] ones_r, ones_n;
  logic [9:0] ms_cnt_r, ms_cnt_n;
  logic       ms_tick_d_r;
  logic       tick_r;
  logic       nonzero_s;
  logic       timer_en_r, running_r, expired_r, expire_pulse_r;

  assign nonzero_s = (tens_r != 4'd0) || (ones_r != 4'd0);

  // Next-state and next-value logic, priority load > start > pause > tick event.
  always_comb begin
    state_n  = state_r;
    tens_n   = tens_r;
    ones_n   = ones_r;
    ms_cnt_n = ms_cnt_r;
    if (load) begin
      tens_n   = bcd_clamp(load_tens);
      ones_n   = bcd_clamp(load_ones);
      ms_cnt_n = 10'd0;
      state_n  = IDLE;
    end else if (start && ((state_r == IDLE) || (state_r == PAUSE))) begin
      if (nonzero_s) begin
        state_n = RUN;
      end else begin
        state_n = EXPIRED;
      end
    end else if (pause && !start && (state_r == RUN)) begin
      state_n = PAUSE;
    end else if (tick_r && (state_r == RUN)) begin
      if (ms_cnt_r == CNT_LAST) begin
        ms_cnt_n = 10'd0;
        if (ones_r != 4'd0) begin
          ones_n = ones_r - 4'd1;
        end else begin
          ones_n = 4'd9;
          tens_n = tens_r - 4'd1;
        end
        // Hitting 00 expires in the same update that produced it.
        if ((tens_n == 4'd0) && (ones_n == 4'd0)) begin
          state_n = EXPIRED;
        end else begin
          state_n = RUN;
        end
      end else begin
        ms_cnt_n = ms_cnt_r + 10'd1;
      end
    end else begin
      state_n = state_r;
    end
  end

  // State, counters and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= IDLE;
      tens_r         <= INIT_TENS;
      ones_r         <= INIT_ONES;
      ms_cnt_r       <= 10'd0;
      ms_tick_d_r    <= 1'b0;
      tick_r         <= 1'b0;
      timer_en_r     <= 1'b0;
      running_r      <= 1'b0;
      expired_r      <= 1'b0;
      expire_pulse_r <= 1'b0;
    end else begin
      state_r        <= state_n;
      tens_r         <= tens_n;
      ones_r         <= ones_n;
      ms_cnt_r       <= ms_cnt_n;
      ms_tick_d_r    <= ms_tick;
      tick_r         <= ms_tick & ~ms_tick_d_r;
      timer_en_r     <= (state_n == RUN);
      running_r      <= (state_n == RUN);
      expired_r      <= (state_n == EXPIRED);
      expire_pulse_r <= (state_n == EXPIRED) && (state_r != EXPIRED);
    end
  end

  assign timer_en     = timer_en_r;
  assign sec_tens     = tens_r;
  assign sec_ones     = ones_r;
  assign running      = running_r;
  assign expired      = expired_r;
  assign expire_pulse = expire_pulse_r;

`ifdef COUNTDOWN_WARN_EN
  logic       warn_r;
  logic [6:0] secs_s;

  assign secs_s = ({3'd0, tens_n} * 7'd10) + {3'd0, ones_n};

  // Low-time warning, only while counting or paused with a nonzero remainder.
  always_ff @(posedge clk) begin
    if (!rst) begin
      warn_r <= 1'b0;
    end else begin
      warn_r <= ((state_n == RUN) || (state_n == PAUSE)) &&
                (secs_s <= WARN_SEC) && (secs_s != 7'd0);
    end
  end

  assign warn = warn_r;
`else
  logic warn_unused_s;
  assign warn_unused_s = ^WARN_SEC;
  assign warn          = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_sec_ctrl.sv
// Directed bench for countdown_sec_ctrl with MS_PER_SEC=4: vector table plus hand-written
// sequences for stuck tick, expiry, load corner cases and reset mid-run.
module tb_countdown_sec_ctrl;

  localparam int MS = 4;
`ifdef COUNTDOWN_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ms_tick = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       timer_en, running, expired, expire_pulse, warn;
  logic [3:0] sec_tens, sec_ones;

  int total = 0;
  int bad = 0;

  countdown_sec_ctrl #(
    .MS_PER_SEC(MS), .INIT_TENS(4'd6), .INIT_ONES(4'd0), .WARN_SEC(7'd10)
  ) dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .load(load),
    .load_tens(load_tens), .load_ones(load_ones), .start(start), .pause(pause),
    .timer_en(timer_en), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .expired(expired), .expire_pulse(expire_pulse), .warn(warn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [3:0] lt;
    logic [3:0] lo;
    logic       st;
    logic       pa;
    logic       tk;
    logic [3:0] et;
    logic [3:0] eo;
    logic       er;
    logic       ee;
    logic       ep;
    logic       ew;
  } vec_t;

  vec_t vecs[$];

  function automatic logic w(input logic x);
    return WARN_ON ? x : 1'b0;
  endfunction

  task automatic add(input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                     input logic st, input logic pa, input logic tk,
                     input logic [3:0] et, input logic [3:0] eo,
                     input logic er, input logic ee, input logic ep, input logic ew);
    vec_t v;
    v.ld = ld; v.lt = lt; v.lo = lo; v.st = st; v.pa = pa; v.tk = tk;
    v.et = et; v.eo = eo; v.er = er; v.ee = ee; v.ep = ep; v.ew = ew;
    vecs.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] et, input logic [3:0] eo,
                         input logic er, input logic ee, input logic ep, input logic ew);
    chk({nm, ".tens"}, int'(sec_tens), int'(et));
    chk({nm, ".ones"}, int'(sec_ones), int'(eo));
    chk({nm, ".running"}, int'(running), int'(er));
    chk({nm, ".timer_en"}, int'(timer_en), int'(er));
    chk({nm, ".expired"}, int'(expired), int'(ee));
    chk({nm, ".expire_pulse"}, int'(expire_pulse), int'(ep));
    chk({nm, ".warn"}, int'(warn), int'(w(ew)));
  endtask

  task automatic pulse();
    ms_tick = 1'b1;
    cyc();
    ms_tick = 1'b0;
    cyc();
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; load_tens = t; load_ones = o;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    // start from reset, load 1,0, run through a tens boundary, then pause/resume
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7)
        add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      else
        add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ((i % 2) == 0), 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++)
      add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ((i % 2) == 0), 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ((i % 2) == 0), 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3)
        add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
      else
        add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ((i % 2) == 0), 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    rst = 1'b0;
    cyc();
    chk_all("reset", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.ms_cnt", int'(dut.ms_cnt_r), 0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      load = vecs[i].ld; load_tens = vecs[i].lt; load_ones = vecs[i].lo;
      start = vecs[i].st; pause = vecs[i].pa; ms_tick = vecs[i].tk;
      cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].et, vecs[i].eo, vecs[i].er,
              vecs[i].ee, vecs[i].ep, vecs[i].ew);
    end
    load = 1'b0; start = 1'b0; pause = 1'b0; ms_tick = 1'b0;

    // 0,8 to expiry: 32 ticks, the last one lands on 00
    repeat (31) pulse();
    chk_all("pre_exp", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    ms_tick = 1'b1;
    cyc();
    chk_all("exp_detect", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    ms_tick = 1'b0;
    cyc();
    chk_all("exp_edge", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_all("exp_hold", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    pulse();
    start = 1'b0;
    chk_all("exp_ignore", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // stuck-high tick counts once
    do_load(4'd2, 4'd5);
    do_start();
    ms_tick = 1'b1;
    repeat (20) cyc();
    chk_all("stuck", 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stuck.ms_cnt", int'(dut.ms_cnt_r), 1);
    ms_tick = 1'b0;
    cyc();
    repeat (2) pulse();
    chk_all("stuck_after2", 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse();
    chk_all("stuck_after3", 4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);

    // warn threshold crossing 11 -> 10
    do_load(4'd1, 4'd1);
    do_start();
    chk_all("warn11", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) pulse();
    chk_all("warn11b", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse();
    chk_all("warn10", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (36) pulse();
    chk_all("warn01", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) pulse();
    chk_all("warn_exp", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // load clamping and zero-load start
    do_load(4'd12, 4'd15);
    chk_all("clamp", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    do_load(4'd0, 4'd0);
    do_start();
    chk_all("zero_start", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_all("zero_hold", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // load with start and a pending tick event at ms_cnt=3: load wins
    do_load(4'd3, 4'd3);
    do_start();
    repeat (3) pulse();
    ms_tick = 1'b1;
    cyc();
    ms_tick = 1'b0;
    load = 1'b1; load_tens = 4'd4; load_ones = 4'd5; start = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    chk_all("load_win", 4'd4, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("load_win.ms_cnt", int'(dut.ms_cnt_r), 0);
    do_start();
    repeat (3) pulse();
    chk_all("load_win3", 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse();
    chk_all("load_win4", 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset mid-run
    pulse();
    rst = 1'b0;
    cyc();
    chk_all("rst_run", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_run.ms_cnt", int'(dut.ms_cnt_r), 0);
    rst = 1'b1;
    cyc();
    chk_all("rst_after", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
